if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of `id_stage` and owns the program counter. It fetches one word at a time from instruction memory over a request/response handshake and presents `pc_out`/`instr`/`valid` to decode. It also handles hazard stalls and branch/jump redirects from EX.

## Interface
- `WORD_SIZE`, 32, instruction width
- `ADDR_SIZE`, 10, byte-address width of PC and instruction memory
- `RESET_PC`, 0, PC value after reset
- `NOP`, 32'h00000013, instruction presented when `valid`=0 (addi x0,x0,0)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `stall`  in  1  hazard unit: hold the IF/ID outputs
- `redirect`  in  1  taken branch/jump from EX
- `redirect_pc`  in  ADDR_SIZE  target of the redirect
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_SIZE  fetch byte address
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  WORD_SIZE  response instruction
- `pc_out`  out  ADDR_SIZE  PC of the presented instruction (to `id_stage` `pc`)
- `instr`  out  WORD_SIZE  presented instruction (to `id_stage` `instr`)
- `valid`  out  1  `instr`/`pc_out` hold a real instruction

## Operation
- Only one memory request is outstanding at a time. `pc` is the next fetch address. `pc` increments by 4 modulo 2^ADDR_SIZE, so 0x3FC wraps to 0x000.
- States:
  - IDLE: entered on reset; goes unconditionally to REQ on the next cycle.
  - REQ: `imem_req`=1, `imem_addr`=`pc`.
    - `imem_ready`=1 → WAIT.
    - Otherwise stay in REQ. The address may change before acceptance.
  - WAIT: `imem_req`=0. On `imem_rvalid`=1:
    - If `stall`=0: load the IF/ID register, set `pc`←`pc`+4, go to REQ.
    - If `stall`=1: capture into a one-entry buffer, go to BUF.
  - BUF: `imem_req`=0. When `stall` falls: load the buffer into IF/ID, set `pc`←`pc`+4, go to REQ.
  - DRAIN: `imem_req`=0. The next `imem_rvalid` is discarded, then go to REQ.
- IF/ID register:
  - When `stall`=0 and no word is loaded this cycle, `valid`←0 and `instr`←NOP (bubble).
  - When `stall`=1, all three outputs hold.
- Redirect has the highest priority and overrides `stall`:
  - `pc`←`redirect_pc`; `valid`←0, `instr`←NOP; the buffer is discarded.
  - From REQ with `imem_ready`=0: stay in REQ. The new address is driven next cycle.
  - From REQ with `imem_ready`=1, or from WAIT: go to DRAIN, because the in-flight word is stale.
  - From WAIT with `imem_rvalid`=1 in the same cycle: the word is discarded, go to REQ.
  - From BUF: go to REQ.
  - From DRAIN: update `pc` and stay in DRAIN. If `imem_rvalid`=1 in the same cycle, discard it and go to REQ.
- `imem_rvalid` in IDLE, REQ or BUF is ignored. It is a memory protocol error and the design does not recover from it.

## Timing
- Reset values while `rst`=0:
  - `state`=IDLE, `pc`=RESET_PC
  - `imem_req`=0, `imem_addr`=RESET_PC
  - `valid`=0, `instr`=NOP, `pc_out`=RESET_PC
- Outputs:
  - `imem_req` and `imem_addr` are Moore outputs, decoded from state and `pc` only.
  - `pc_out`, `instr` and `valid` are registered.
- Latency with a zero-wait memory (ready in REQ, rvalid next cycle):
  - Cycle 0: REQ accepted.
  - Cycle 1: rvalid.
  - Cycle 2: `valid`=1 at the IF/ID outputs; the next REQ is issued in the same cycle.
- Throughput is therefore one instruction per 2 cycles.
- A redirect in cycle N presents a bubble at the outputs in cycle N+1. The first target fetch is requested in cycle N+1, or later if the stage must DRAIN.
- Deasserting reset mid-transaction: any response still pending from before reset is not tracked. The memory is reset on the same `rst`.

## Test plan
- Reset release, zero-wait memory returning `imem_rdata`=addr+0x100:
  - Requests at 0x000, 0x004, 0x008 in cycles 1, 3, 5.
  - `valid`=1 with `pc_out`=0x000, `instr`=0x100 in cycle 3; each subsequent instruction 2 cycles later.
- Memory with `imem_ready` held low for 3 cycles:
  - `imem_req`=1 and `imem_addr`=0x000 stable throughout.
  - `valid` stays 0 until 2 cycles after acceptance.
- `stall` raised while the word for 0x004 is in flight:
  - Outputs hold at `pc_out`=0x000 for the whole stall.
  - The 0x004 word appears the cycle after `stall` falls, with no word lost or duplicated.
- `redirect`=1, `redirect_pc`=0x040 while in WAIT for 0x008:
  - The 0x008 response is discarded.
  - `valid`=0 the next cycle; the next request is to 0x040; `pc_out`=0x040 with its matching data follows.
- `redirect`=1 together with `stall`=1, and with `imem_rvalid`=1 in the same cycle:
  - Flush wins: `valid`=0.
  - The rvalid word is dropped and the next request is to the target.
- `RESET_PC`=0x3F8, free run:
  - Requests 0x3F8, 0x3FC, 0x000, so the PC wraps.
  - Asserting `rst` mid-WAIT forces all outputs to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
module if_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] NOP       = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [ADDR_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 valid
);

    localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BUF,
        S_DRAIN
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [ADDR_SIZE-1:0]   pc;
    logic [ADDR_SIZE-1:0]   pc_n;
    logic [WORD_SIZE-1:0]   buf_word;
    logic [WORD_SIZE-1:0]   buf_word_n;
    logic                   load;
    logic [WORD_SIZE-1:0]   load_word;

    // Moore memory-side outputs: request only in REQ, address is always the fetch PC
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    // State, fetch PC and stall buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            buf_word <= NOP;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            buf_word <= buf_word_n;
        end
    end

    // Next-state logic; redirect beats stall and kills any in-flight or buffered word
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        buf_word_n = buf_word;
        load       = 1'b0;
        load_word  = imem_rdata;

        if (redirect) begin
            pc_n = redirect_pc;
        end

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (imem_ready) begin
                    // an accepted request under redirect fetches a stale word
                    state_n = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_n = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    if (!stall) begin
                        load    = 1'b1;
                        pc_n    = pc + PC_STEP;
                        state_n = S_REQ;
                    end else begin
                        buf_word_n = imem_rdata;
                        state_n    = S_BUF;
                    end
                end
            end
            S_BUF: begin
                if (redirect) begin
                    state_n = S_REQ;
                end else if (!stall) begin
                    load      = 1'b1;
                    load_word = buf_word;
                    pc_n      = pc + PC_STEP;
                    state_n   = S_REQ;
                end
            end
            S_DRAIN: begin
                // swallow the stale response, then refetch from the current pc
                if (imem_rvalid) begin
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // IF/ID register: flush on redirect, load on delivery, bubble when free, hold on stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            instr  <= NOP;
            pc_out <= RESET_PC;
        end else if (redirect) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (load) begin
            valid  <= 1'b1;
            instr  <= load_word;
            pc_out <= pc;
        end else if (!stall) begin
            valid <= 1'b0;
            instr <= NOP;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed testbench for if_stage
module tb_if_stage;

    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [9:0]  pc_out;
    logic [31:0] instr;
    logic        valid;

    // second instance with a wrapping reset PC, free-running zero-wait memory
    logic        stall2;
    logic        redirect2;
    logic [9:0]  redirect_pc2;
    logic        req2;
    logic [9:0]  addr2;
    logic        ready2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [9:0]  pc_out2;
    logic [31:0] instr2;
    logic        valid2;

    int pass_cnt;
    int total_cnt;

    // memory model state
    int         hold_cnt;
    int         lat;
    int         pend_cnt;
    logic [9:0] pend_addr;
    logic       pend2;
    logic [9:0] pend2_addr;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr       (instr),
        .valid       (valid)
    );

    if_stage #(.RESET_PC(10'h3F8)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ready  (ready2),
        .imem_rvalid (rvalid2),
        .imem_rdata  (rdata2),
        .pc_out      (pc_out2),
        .instr       (instr2),
        .valid       (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // advance to the middle of the next cycle and drive the memory responses for it
    task automatic cyc();
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'(pend_addr) + 32'h100;
            end
        end
        imem_ready = (hold_cnt == 0);
        if (imem_req) begin
            if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
            else begin
                pend_cnt  = lat;
                pend_addr = imem_addr;
            end
        end
        rvalid2 = pend2;
        rdata2  = 32'(pend2_addr) + 32'h100;
        pend2   = req2;
        pend2_addr = addr2;
        if (!rst) begin
            pend_cnt    = 0;
            pend2       = 1'b0;
            imem_rvalid = 1'b0;
            rvalid2     = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        hold_cnt    = 0;
        lat         = 1;
        pend_cnt    = 0;
        pend2       = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        cyc();
        total_cnt++;
        if (imem_req !== 1'b0 || imem_addr !== 10'h000 || valid !== 1'b0 ||
            instr !== NOP_W || pc_out !== 10'h000) begin
            $display("FAIL reset_values: req=%b addr=%h valid=%b instr=%h pc_out=%h, required 0 000 0 %h 000",
                     imem_req, imem_addr, valid, instr, pc_out, NOP_W);
        end else pass_cnt++;
        total_cnt++;
        if (addr2 !== 10'h3F8 || pc_out2 !== 10'h3F8) begin
            $display("FAIL reset_pc_wrap: addr=%h pc_out=%h, required 3f8 3f8", addr2, pc_out2);
        end else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        logic [6:0] exp_req;
        logic [6:0] exp_valid;
        logic [9:0] exp_addr [1:7];
        logic [31:0] exp_instr [1:7];
        exp_req   = 7'b1010101;   // bit c-1 for cycle c
        exp_valid = 7'b1010100;
        exp_addr  = '{10'h000, 10'h000, 10'h004, 10'h004, 10'h008, 10'h008, 10'h00C};
        exp_instr = '{NOP_W, NOP_W, 32'h100, NOP_W, 32'h104, NOP_W, 32'h108};
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            cyc();
            total_cnt++;
            if (imem_req !== exp_req[c-1] || (exp_req[c-1] && imem_addr !== exp_addr[c]) ||
                valid !== exp_valid[c-1] || instr !== exp_instr[c]) begin
                $display("FAIL zero_wait cycle %0d: req=%b addr=%h valid=%b instr=%h, required %b %h %b %h",
                         c, imem_req, imem_addr, valid, instr, exp_req[c-1], exp_addr[c],
                         exp_valid[c-1], exp_instr[c]);
            end else pass_cnt++;
        end
        total_cnt++;
        if (pc_out !== 10'h008) begin
            $display("FAIL zero_wait_pc_out: got %h, required 008", pc_out);
        end else pass_cnt++;
    endtask

    task automatic test_ready_low();
        do_reset();
        hold_cnt = 3;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c <= 4) begin
                total_cnt++;
                if (imem_req !== 1'b1 || imem_addr !== 10'h000 || valid !== 1'b0) begin
                    $display("FAIL ready_low_req cycle %0d: req=%b addr=%h valid=%b, required 1 000 0",
                             c, imem_req, imem_addr, valid);
                end else pass_cnt++;
            end else if (c == 5) begin
                total_cnt++;
                if (imem_req !== 1'b0 || valid !== 1'b0) begin
                    $display("FAIL ready_low_wait: req=%b valid=%b, required 0 0", imem_req, valid);
                end else pass_cnt++;
            end else begin
                total_cnt++;
                if (valid !== 1'b1 || pc_out !== 10'h000 || instr !== 32'h100) begin
                    $display("FAIL ready_low_deliver: valid=%b pc_out=%h instr=%h, required 1 000 00000100",
                             valid, pc_out, instr);
                end else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) cyc();
        stall = 1'b1;
        for (int c = 4; c <= 7; c++) begin
            cyc();
            total_cnt++;
            if (valid !== 1'b1 || pc_out !== 10'h000 || instr !== 32'h100) begin
                $display("FAIL stall_hold cycle %0d: valid=%b pc_out=%h instr=%h, required 1 000 00000100",
                         c, valid, pc_out, instr);
            end else pass_cnt++;
        end
        stall = 1'b0;
        cyc();
        total_cnt++;
        if (valid !== 1'b1 || pc_out !== 10'h004 || instr !== 32'h104 ||
            imem_req !== 1'b1 || imem_addr !== 10'h008) begin
            $display("FAIL stall_release: valid=%b pc_out=%h instr=%h req=%b addr=%h, required 1 004 00000104 1 008",
                     valid, pc_out, instr, imem_req, imem_addr);
        end else pass_cnt++;
        repeat (2) cyc();
        total_cnt++;
        if (valid !== 1'b1 || pc_out !== 10'h008 || instr !== 32'h108) begin
            $display("FAIL stall_next: valid=%b pc_out=%h instr=%h, required 1 008 00000108",
                     valid, pc_out, instr);
        end else pass_cnt++;
    endtask

    task automatic test_redirect_drain();
        do_reset();
        repeat (4) cyc();
        lat = 2;
        cyc();              // cycle 5: request for 0x008 accepted
        cyc();              // cycle 6: waiting, response not yet back
        redirect    = 1'b1;
        redirect_pc = 10'h040;
        cyc();              // cycle 7: stale 0x008 response arrives in DRAIN
        redirect = 1'b0;
        lat      = 1;
        total_cnt++;
        if (valid !== 1'b0 || instr !== NOP_W || imem_req !== 1'b0) begin
            $display("FAIL redirect_bubble: valid=%b instr=%h req=%b, required 0 %h 0",
                     valid, instr, imem_req, NOP_W);
        end else pass_cnt++;
        cyc();              // cycle 8
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h040 || valid !== 1'b0) begin
            $display("FAIL redirect_target_req: req=%b addr=%h valid=%b, required 1 040 0",
                     imem_req, imem_addr, valid);
        end else pass_cnt++;
        repeat (2) cyc();   // cycle 10
        total_cnt++;
        if (valid !== 1'b1 || pc_out !== 10'h040 || instr !== 32'h140) begin
            $display("FAIL redirect_target_data: valid=%b pc_out=%h instr=%h, required 1 040 00000140",
                     valid, pc_out, instr);
        end else pass_cnt++;
    endtask

    task automatic test_redirect_stall_rvalid();
        do_reset();
        repeat (3) cyc();
        stall = 1'b1;
        cyc();              // cycle 4: 0x004 response arrives with stall and redirect
        redirect    = 1'b1;
        redirect_pc = 10'h080;
        cyc();              // cycle 5
        redirect = 1'b0;
        stall    = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || instr !== NOP_W || imem_req !== 1'b1 || imem_addr !== 10'h080) begin
            $display("FAIL flush_over_stall: valid=%b instr=%h req=%b addr=%h, required 0 %h 1 080",
                     valid, instr, imem_req, imem_addr, NOP_W);
        end else pass_cnt++;
        cyc();              // cycle 6
        total_cnt++;
        if (valid !== 1'b0) begin
            $display("FAIL flush_dropped_word: valid=%b pc_out=%h, required valid 0", valid, pc_out);
        end else pass_cnt++;
        cyc();              // cycle 7
        total_cnt++;
        if (valid !== 1'b1 || pc_out !== 10'h080 || instr !== 32'h180) begin
            $display("FAIL flush_target_data: valid=%b pc_out=%h instr=%h, required 1 080 00000180",
                     valid, pc_out, instr);
        end else pass_cnt++;
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1 || c == 3 || c == 5) begin
                total_cnt++;
                if (req2 !== 1'b1 || addr2 !== (c == 1 ? 10'h3F8 : c == 3 ? 10'h3FC : 10'h000)) begin
                    $display("FAIL wrap_req cycle %0d: req=%b addr=%h", c, req2, addr2);
                end else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if (valid2 !== 1'b1 || pc_out2 !== 10'h3F8 || instr2 !== 32'h4F8) begin
                    $display("FAIL wrap_data: valid=%b pc_out=%h instr=%h, required 1 3f8 000004f8",
                             valid2, pc_out2, instr2);
                end else pass_cnt++;
            end
        end
        cyc();              // cycle 6: in WAIT for 0x000
        #1;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (req2 !== 1'b0 || addr2 !== 10'h3F8 || valid2 !== 1'b0 ||
            instr2 !== NOP_W || pc_out2 !== 10'h3F8) begin
            $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h pc_out=%h, required 0 3f8 0 %h 3f8",
                     req2, addr2, valid2, instr2, pc_out2, NOP_W);
        end else pass_cnt++;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        stall2       = 1'b0;
        redirect2    = 1'b0;
        redirect_pc2 = '0;
        ready2       = 1'b1;
        rvalid2      = 1'b0;
        rdata2       = '0;
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        pend_addr    = '0;
        pend2_addr   = '0;

        test_reset();
        test_zero_wait();
        test_ready_low();
        test_stall();
        test_redirect_drain();
        test_redirect_stall_rvalid();
        test_wrap_and_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
